// File: rtl/adder_result_fifo.sv
// First-word-fall-through result FIFO placed downstream of sync_adder.
// Results that arrive while the FIFO is full are dropped and raise a sticky overflow flag.
module adder_result_fifo #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [WIDTH:0]    in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH:0]    out_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  input  logic              ovf_clr
);

  localparam logic [ADDR_W-1:0] PTR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ZERO  = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   CNT_FULL  = (ADDR_W+1)'(DEPTH);

  logic [WIDTH:0]    mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              push_s, pop_s, drop_s;

  assign empty     = (count_q == CNT_ZERO);
  assign full      = (count_q == CNT_FULL);
  assign out_valid = ~empty;
  assign count     = count_q;
  assign overflow  = overflow_q;
  // The read port is forced to zero when empty so stale storage never reaches the bus.
  assign out_data  = empty ? {(WIDTH+1){1'b0}} : mem_q[rd_ptr_q];

  // Next-state for pointers, occupancy and the sticky overflow flag.
  always_comb begin
    pop_s      = out_valid & out_ready;
    push_s     = in_valid & (~full | pop_s);
    drop_s     = in_valid & full & ~pop_s;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    // A drop on the same edge as a clear must leave the flag set.
    if (drop_s) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= {ADDR_W{1'b0}};
      rd_ptr_q   <= {ADDR_W{1'b0}};
      count_q    <= CNT_ZERO;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_adder_result_fifo.sv
// Scoreboard bench for adder_result_fifo: directed scenarios followed by random traffic,
// checked against a queue-based reference of FIFO contents and a sticky overflow bit.
module tb_adder_result_fifo;

  localparam int W = 8;
  localparam int D = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [8:0] in_data = 9'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [8:0] out_data;
  logic       full, empty, overflow;
  logic [3:0] count;
  logic       ovf_clr = 1'b0;

  int checks = 0;
  int failures = 0;
  int sb[$];
  int model_cnt = 0;
  bit model_ovf = 1'b0;

  adder_result_fifo #(.WIDTH(W), .DEPTH(D), .ADDR_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .full(full), .empty(empty), .count(count), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_status();
    chk("count", int'(count), model_cnt);
    chk("empty", int'(empty), int'(model_cnt == 0));
    chk("full", int'(full), int'(model_cnt == D));
    chk("out_valid", int'(out_valid), int'(model_cnt > 0));
    chk("overflow", int'(overflow), int'(model_ovf));
    if (model_cnt == 0) chk("out_data_zero", int'(out_data), 0);
    else if (sb.size() > 0) chk("head_data", int'(out_data), sb[0]);
  endtask

  // One clock of stimulus: called at posedge+1, predicts the effect of the next edge.
  task automatic step(bit v, int d, bit r, bit c);
    bit pop, push, drop;
    in_valid  = v;
    in_data   = 9'(d);
    out_ready = r;
    ovf_clr   = c;
    chk_status();
    pop  = (model_cnt > 0) && r;
    push = v && ((model_cnt < D) || pop);
    drop = v && (model_cnt == D) && !pop;
    if (push) sb.push_back(d & 511);
    model_cnt = model_cnt + int'(push) - int'(pop);
    if (drop) model_ovf = 1'b1;
    else if (c) model_ovf = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted head entry must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pop_unexpected: got %0d expected no data at %0t", out_data, $time);
      end else begin
        chk("pop_data", int'(out_data), sb.pop_front());
      end
    end
  end

  initial begin
    // Reset state
    #12;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_out_data", int'(out_data), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single result 15+25
    step(1'b1, 15 + 25, 1'b0, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0);

    // Fill, drop 99, drain
    for (int i = 1; i <= 8; i++) step(1'b1, i, 1'b0, 1'b0);
    step(1'b1, 99, 1'b0, 1'b0);
    chk("fill_ovf", int'(overflow), 1);
    for (int i = 0; i < 8; i++) step(1'b0, 0, 1'b1, 1'b0);
    step(1'b0, 0, 1'b0, 1'b1);

    // Full push+pop of 300, pointers wrap
    for (int i = 1; i <= 8; i++) step(1'b1, i, 1'b0, 1'b0);
    step(1'b1, 300, 1'b1, 1'b0);
    chk("fullpp_count", int'(count), 8);
    chk("fullpp_ovf", int'(overflow), 0);
    for (int i = 0; i < 8; i++) step(1'b0, 0, 1'b1, 1'b0);

    // Carry preservation and overflow clear priority
    step(1'b1, 510, 1'b0, 1'b0);
    chk("carry_data", int'(out_data), 9'h1FE);
    for (int i = 0; i < 7; i++) step(1'b1, i + 20, 1'b0, 1'b0);
    step(1'b1, 77, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b1);
    chk("ovf_cleared", int'(overflow), 0);
    step(1'b1, 88, 1'b0, 1'b1);
    chk("ovf_set_wins", int'(overflow), 1);
    for (int i = 0; i < 8; i++) step(1'b0, 0, 1'b1, 1'b0);
    step(1'b0, 0, 1'b0, 1'b1);

    // Reset mid-operation with five entries held
    for (int i = 0; i < 5; i++) step(1'b1, 200 + i, 1'b0, 1'b0);
    chk("pre_rst_count", int'(count), 5);
    in_valid = 1'b0;
    out_ready = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("midrst_empty", int'(empty), 1);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_count", int'(count), 0);
    sb.delete();
    model_cnt = 0;
    model_ovf = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 7, 1'b0, 1'b0);
    chk("post_rst_data", int'(out_data), 7);
    step(1'b0, 0, 1'b1, 1'b0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 1)), int'($urandom_range(0, 510)),
           1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 15) == 0));
    end
    for (int i = 0; i < 10; i++) step(1'b0, 0, 1'b1, 1'b0);
    chk("final_sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
